// File: rtl/isa_pkg.sv
// Shared 9-bit ISA encoding: word types, funct codes, command ops
// and the fixed MOVE encoding table used by encoder and decoder.
package isa_pkg;

  localparam logic [1:0] ITYPE_R  = 2'b00;
  localparam logic [1:0] ITYPE_BR = 2'b01;
  localparam logic [1:0] ITYPE_I  = 2'b10;
  localparam logic [1:0] ITYPE_LS = 2'b11;

  localparam logic [2:0] FUNCT_AND = 3'b000;
  localparam logic [2:0] FUNCT_ADD = 3'b001;

  localparam logic [8:0] DONE_WORD = 9'b010000000;

  typedef enum logic [3:0] {
    AND  = 4'd0,
    ADD  = 4'd1,
    ADDI = 4'd2,
    BR   = 4'd3,
    LD   = 4'd4,
    ST   = 4'd5,
    MOVE = 4'd6,
    LI   = 4'd7,
    DONE = 4'd8
  } op_e;

  function automatic logic [8:0] move_word(
    input logic [1:0] src,
    input logic [1:0] dst
  );
    logic [8:0] w;
    case ({src, dst})
      4'b0001: w = 9'b000000100;
      4'b0010: w = 9'b000001000;
      4'b0011: w = 9'b000001100;
      4'b0100: w = 9'b000001001;
      4'b0110: w = 9'b000001101;
      4'b0111: w = 9'b000001110;
      4'b1000: w = 9'b000010100;
      4'b1001: w = 9'b000011000;
      4'b1011: w = 9'b000011100;
      4'b1100: w = 9'b000011001;
      4'b1101: w = 9'b000011101;
      4'b1110: w = 9'b000011110;
      default: w = 9'b000000000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_emitter_if.sv
// Command handshake from the loader plus the imem write port.
// master = loader side, slave = emitter side.
interface instr_emitter_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [1:0]        cmd_ra;
  logic [1:0]        cmd_rb;
  logic [6:0]        cmd_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [8:0]        imem_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_ra,
    output cmd_rb, cmd_imm,
    input  cmd_ready,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra,
    input  cmd_rb, cmd_imm,
    output cmd_ready,
    output imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encode.sv
// Combinational command-to-word encoder; idx_i selects the
// second word of a pseudo-op expansion.
module instr_encode
  import isa_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [1:0] ra_i,
  input  logic [1:0] rb_i,
  input  logic [6:0] imm_i,
  input  logic       idx_i,
  output logic [8:0] word_o,
  output logic       illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      AND:  word_o = {ITYPE_R, FUNCT_AND, ra_i, rb_i};
      ADD:  word_o = {ITYPE_R, FUNCT_ADD, ra_i, rb_i};
      ADDI: word_o = {ITYPE_I, imm_i};
      BR: begin
        word_o    = {ITYPE_BR, imm_i};
        illegal_o = (imm_i == 7'd0);
      end
      LD:   word_o = {ITYPE_LS, 1'b0, ra_i, rb_i, 2'b00};
      ST:   word_o = {ITYPE_LS, 1'b1, ra_i, rb_i, 2'b00};
      MOVE: begin
        word_o    = move_word(ra_i, rb_i);
        illegal_o = (ra_i == rb_i);
      end
      LI: begin
        // r1 is the only ADDI target; relocate via MOVE 1->rd
        if (idx_i) word_o = move_word(2'd1, ra_i);
        else       word_o = {ITYPE_I, imm_i};
      end
      DONE:    word_o = DONE_WORD;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_emitter.sv
// Accepts loader commands, encodes them and writes the words
// sequentially into instruction memory.
module instr_emitter
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  instr_emitter_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              finished,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT2,
    HALTED
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   pc_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        wdata_q;
  logic              fin_q;
  logic              err_q;
  logic [1:0]        ra_q;

  logic              second;
  logic              accept;
  logic              two_word;
  logic              fits;
  logic [ADDR_W+1:0] need;
  logic [3:0]        enc_op;
  logic [1:0]        enc_ra;
  logic [8:0]        word;
  logic              illegal;

  assign second = (state_q == EMIT2);
  assign bus.cmd_ready = (state_q == IDLE) && !reset;
  assign accept = bus.cmd_valid && bus.cmd_ready;

  assign two_word = (bus.cmd_op == LI)
                 && (bus.cmd_ra != 2'd1);

  // both words of an LI must fit before anything is written
  assign need = {1'b0, pc_q}
              + {{ADDR_W{1'b0}}, two_word, ~two_word};
  assign fits = need <= (ADDR_W+2)'(DEPTH);

  assign enc_op = second ? LI : bus.cmd_op;
  assign enc_ra = second ? ra_q : bus.cmd_ra;

  instr_encode u_enc (
    .op_i      (enc_op),
    .ra_i      (enc_ra),
    .rb_i      (bus.cmd_rb),
    .imm_i     (bus.cmd_imm),
    .idx_i     (second),
    .word_o    (word),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      ra_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else if (!fits) begin
              err_q   <= 1'b1;
              state_q <= HALTED;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= pc_q[ADDR_W-1:0];
              wdata_q <= word;
              pc_q    <= pc_q + 1'b1;
              ra_q    <= bus.cmd_ra;
              if (bus.cmd_op == DONE) begin
                fin_q   <= 1'b1;
                state_q <= HALTED;
              end else if (two_word) begin
                state_q <= EMIT2;
              end
            end
          end
        end
        EMIT2: begin
          we_q    <= 1'b1;
          addr_q  <= pc_q[ADDR_W-1:0];
          wdata_q <= word;
          pc_q    <= pc_q + 1'b1;
          state_q <= IDLE;
        end
        HALTED: begin
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign word_count     = pc_q;
  assign finished       = fin_q;
  assign error          = err_q;

endmodule
